// File: rtl/ale_bus_memory.sv
// Purpose : memory slave for the SAM CPU external bus (ALE address phase, En/Rw access phase).
// Latency : ready pulses WAIT_STATES+1 clk edges after the accepting edge; reads also update data_out on that edge.
// Backpr. : the CPU holds En until ready; dropping En or raising ALE abandons the access (no write, no ready).
// Optional feature macro: BUS_MEM_BURST_EN (holding En in DONE chains accesses to incrementing addresses).
module ale_bus_memory #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ALE,
    input  logic [ADDR_W-1:0] Address_Bus,
    input  logic              En,
    input  logic              Rw,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              ready,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LD  = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH32 = 32'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    // Set on entry to DONE: the access itself is performed on the next edge.
    logic              fire;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              do_access;
    logic [ADDR_W-1:0] next_addr;

    assign in_range  = (32'(addr_q) < DEPTH32);
    assign idx       = addr_q[IDX_W-1:0];
    assign rd_word   = mem[idx];
    assign do_access = (state == S_DONE) && fire && En && !ALE && !rst;
    assign next_addr = (32'(addr_q) >= DEPTH32 - 32'd1) ? '0 : addr_q + 1'b1;

    // Storage array: no reset so contents survive rst; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (do_access && !rw_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    // Bus FSM: address latch, access accept, wait-state count and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            cnt      <= '0;
            fire     <= 1'b0;
            data_out <= '0;
            data_oe  <= 1'b0;
            ready    <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            ready   <= 1'b0;
            bus_err <= 1'b0;
            if (ALE) begin
                // Address phase wins over everything and drops any access in flight.
                addr_q  <= Address_Bus;
                state   <= S_IDLE;
                data_oe <= 1'b0;
                fire    <= 1'b0;
            end else if (!En) begin
                // En low aborts a pending access or closes a completed one.
                state   <= S_IDLE;
                data_oe <= 1'b0;
                fire    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        rw_q    <= Rw;
                        wdata_q <= data_in;
                        data_oe <= Rw;
                        cnt     <= WS_LD;
                        if (WAIT_STATES == 0) begin
                            state <= S_DONE;
                            fire  <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state <= S_DONE;
                            fire  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (fire) begin
                            ready   <= 1'b1;
                            bus_err <= !in_range;
                            fire    <= 1'b0;
                            if (rw_q) begin
                                data_out <= in_range ? rd_word : '0;
                            end
`ifdef BUS_MEM_BURST_EN
                            // Chain the next access of the same direction at the following address.
                            addr_q  <= next_addr;
                            wdata_q <= data_in;
                            cnt     <= WS_LD;
                            if (WAIT_STATES == 0) begin
                                fire <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
`endif
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef BUS_MEM_BURST_EN
    // Without bursting the incremented address is never needed.
    logic unused_next;
    assign unused_next = ^next_addr;
`endif

endmodule
